// File: rtl/decode_stage_skid_if.sv
// Handshake and payload bundle between fetch, the decode skid stage and execute.
// The slave view belongs to the decode stage; the master view belongs to whoever
// drives fetch-side inputs and consumes execute-side outputs.
interface decode_stage_skid_if #(
    parameter int OPC_W     = 5,
    parameter int REG_W     = 4,
    parameter int IMM_IN_W  = 16,
    parameter int IMM_OUT_W = 32,
    parameter int CNT_W     = 16
) ();
    // Fetch side
    logic                 in_valid;
    logic                 in_ready;
    logic [OPC_W-1:0]     opcode_in;
    logic [REG_W-1:0]     dest_in;
    logic [REG_W-1:0]     s1_in;
    logic [REG_W-1:0]     s2_in;
    logic [IMM_IN_W-1:0]  imm_in;
    logic                 flush;

    // Execute side
    logic                 out_valid;
    logic                 out_ready;
    logic [OPC_W-1:0]     opcode_out;
    logic [REG_W-1:0]     dest_out;
    logic [REG_W-1:0]     s1_out;
    logic [REG_W-1:0]     s2_out;
    logic [IMM_OUT_W-1:0] imm_out;
    logic [CNT_W-1:0]     stall_cnt;

    modport slave (
        input  in_valid, opcode_in, dest_in, s1_in, s2_in, imm_in, flush, out_ready,
        output in_ready, out_valid, opcode_out, dest_out, s1_out, s2_out, imm_out, stall_cnt
    );

    modport master (
        output in_valid, opcode_in, dest_in, s1_in, s2_in, imm_in, flush, out_ready,
        input  in_ready, out_valid, opcode_out, dest_out, s1_out, s2_out, imm_out, stall_cnt
    );
endinterface

// File: rtl/decode_stage_skid.sv
// Decode pipeline register with a 2-entry skid buffer between fetch and execute.
// The main entry drives the execute-side outputs directly; the skid entry absorbs
// the one instruction that may arrive while execute is stalling, so in_ready is
// a pure flop output with no combinational path from out_ready. The immediate
// is extended once at capture, and a saturating counter tracks stalled cycles.
module decode_stage_skid #(
    parameter int OPC_W     = 5,
    parameter int REG_W     = 4,
    parameter int IMM_IN_W  = 16,
    parameter int IMM_OUT_W = 32,
    parameter int SIGN_EXT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_stage_skid_if.slave   bus
);

    typedef struct packed {
        logic [OPC_W-1:0]     opc;
        logic [REG_W-1:0]     dest;
        logic [REG_W-1:0]     s1;
        logic [REG_W-1:0]     s2;
        logic [IMM_OUT_W-1:0] imm;
    } payload_t;

    // Widen the fetch immediate; the signed cast replicates the MSB when enabled.
    function automatic logic [IMM_OUT_W-1:0] ext_imm(input logic [IMM_IN_W-1:0] imm);
        logic signed [IMM_IN_W-1:0] simm;
        simm = imm;
        if (SIGN_EXT != 0) begin
            return IMM_OUT_W'(simm);
        end
        return IMM_OUT_W'(imm);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == '1) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    payload_t         in_p0;
    payload_t         main_p1;
    payload_t         skid_p1;
    logic             main_vld_p1;
    logic             skid_vld_p1;
    logic [CNT_W-1:0] stall_p1;
    logic             accept;
    logic             drain;

    // ---- stage 0: capture-side payload and handshake terms ----
    assign in_p0 = '{opc:  bus.opcode_in,
                     dest: bus.dest_in,
                     s1:   bus.s1_in,
                     s2:   bus.s2_in,
                     imm:  ext_imm(bus.imm_in)};

    // in_ready depends only on the skid flop, so accepting never needs out_ready.
    assign accept = bus.in_valid & ~skid_vld_p1;
    assign drain  = main_vld_p1 & bus.out_ready;

    // Main/skid entries: reset and flush empty both; otherwise refill in FIFO order.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (!main_vld_p1 || drain) begin
            if (skid_vld_p1) begin
                // Older skid instruction advances; a new one (if any) backfills skid.
                main_p1     <= skid_p1;
                main_vld_p1 <= 1'b1;
                skid_vld_p1 <= accept;
                if (accept) begin
                    skid_p1 <= in_p0;
                end
            end else begin
                main_vld_p1 <= accept;
                if (accept) begin
                    main_p1 <= in_p0;
                end
            end
        end else if (accept) begin
            // Main is held by a stalled execute stage: park the arrival in skid.
            skid_p1     <= in_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    // Stall counter: counts offered-but-refused cycles, survives flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_p1 <= '0;
        end else if (main_vld_p1 && !bus.out_ready) begin
            stall_p1 <= sat_inc(stall_p1);
        end
    end

    // ---- stage 1: registered outputs ----
    assign bus.in_ready   = ~skid_vld_p1;
    assign bus.out_valid  = main_vld_p1;
    assign bus.opcode_out = main_p1.opc;
    assign bus.dest_out   = main_p1.dest;
    assign bus.s1_out     = main_p1.s1;
    assign bus.s2_out     = main_p1.s2;
    assign bus.imm_out    = main_p1.imm;
    assign bus.stall_cnt  = stall_p1;

endmodule
